// File: rtl/guess_game_pkg.sv
// Shared types and constants for the number-guessing game controller.
// Holds the controller state enum, the default operand width, the default
// guess limit and the width of the attempt counter.
package guess_game_pkg;

    localparam int unsigned GG_WIDTH     = 4;
    localparam int unsigned GG_MAX_TRIES = 5;
    localparam int unsigned GG_TRY_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GUESS,
        COMPARE,
        WIN,
        LOSE
    } game_state_t;

endpackage

// File: rtl/guess_game_ctrl_try_counter.sv
// try_counter: saturating attempt counter for the guessing game.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous clear (wins over inc)
//   inc        : count one attempt, saturating at MAX
//   count      : registered attempt count
//   term_c     : combinational, high when count + 1 == MAX
module try_counter
    import guess_game_pkg::*;
#(
    parameter int unsigned MAX = GG_MAX_TRIES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    output logic [GG_TRY_W-1:0] count,
    output logic                term_c
);

    localparam int unsigned EXT_W = GG_TRY_W + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX);

    // One extra bit so count + 1 cannot wrap before the compare.
    logic [EXT_W-1:0] count_inc;

    assign count_inc = {1'b0, count} + EXT_W'(1);
    assign term_c    = (count_inc == MAX_EXT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && ({1'b0, count} < MAX_EXT)) begin
            count <= count_inc[GG_TRY_W-1:0];
        end
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: sequential controller for a number-guessing game that
// drives an external 4-bit magnitude comparator and consumes its flags.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   secret_load/secret_in : start a new game with a secret (priority strobe)
//   guess_valid/guess_in  : guess offered; guess_ready accepts it
//   cmp_a, cmp_b          : registered guess / secret to the comparator
//   a_gt_b/a_lt_b/a_eq_b  : comparator flags, sampled in the compare cycle
//   hint_high, hint_low   : last wrong guess was too high / too low
//   win, lose             : sticky game result until the next load
//   tries_used            : guesses counted in the current game
//   cmp_err               : only with GUESS_GAME_FLAG_CHECK_EN; one-cycle
//                           pulse when the comparator flags are not one-hot
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int unsigned WIDTH     = GG_WIDTH,
    parameter int unsigned MAX_TRIES = GG_MAX_TRIES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                secret_load,
    input  logic [WIDTH-1:0]    secret_in,
    input  logic                guess_valid,
    input  logic [WIDTH-1:0]    guess_in,
    output logic                guess_ready,
    output logic [WIDTH-1:0]    cmp_a,
    output logic [WIDTH-1:0]    cmp_b,
    input  logic                a_gt_b,
    input  logic                a_lt_b,
    input  logic                a_eq_b,
    output logic                hint_high,
    output logic                hint_low,
    output logic                win,
    output logic                lose,
`ifdef GUESS_GAME_FLAG_CHECK_EN
    output logic                cmp_err,
`endif
    output logic [GG_TRY_W-1:0] tries_used
);

    game_state_t      state, state_d;
    logic [WIDTH-1:0] cmp_a_d, cmp_b_d;
    logic             hint_high_d, hint_low_d, win_d, lose_d;
    logic             cnt_clear, cnt_inc, term_c;
    logic             flag_err_c;

`ifdef GUESS_GAME_FLAG_CHECK_EN
    logic             cmp_err_d;

    // Exactly one comparator flag must be set in a compare cycle.
    assign flag_err_c = !(({a_gt_b, a_lt_b, a_eq_b} == 3'b100) ||
                          ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) ||
                          ({a_gt_b, a_lt_b, a_eq_b} == 3'b001));
`else
    assign flag_err_c = 1'b0;
`endif

    try_counter #(
        .MAX (MAX_TRIES)
    ) u_try_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .count  (tries_used),
        .term_c (term_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cmp_a_d     = cmp_a;
        cmp_b_d     = cmp_b;
        hint_high_d = hint_high;
        hint_low_d  = hint_low;
        win_d       = win;
        lose_d      = lose;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
`ifdef GUESS_GAME_FLAG_CHECK_EN
        cmp_err_d   = 1'b0;
`endif

        if (secret_load) begin
            cmp_b_d     = secret_in;
            cnt_clear   = 1'b1;
            hint_high_d = 1'b0;
            hint_low_d  = 1'b0;
            win_d       = 1'b0;
            lose_d      = 1'b0;
            state_d     = WAIT_GUESS;
        end else begin
            case (state)
                WAIT_GUESS: begin
                    if (guess_valid && guess_ready) begin
                        cmp_a_d     = guess_in;
                        hint_high_d = 1'b0;
                        hint_low_d  = 1'b0;
                        state_d     = COMPARE;
                    end
                end
                COMPARE: begin
                    if (flag_err_c) begin
`ifdef GUESS_GAME_FLAG_CHECK_EN
                        cmp_err_d = 1'b1;
`endif
                        state_d   = WAIT_GUESS;
                    end else begin
                        cnt_inc = 1'b1;
                        if (a_eq_b) begin
                            win_d   = 1'b1;
                            state_d = WIN;
                        end else begin
                            // No flag at all is treated as too low.
                            hint_high_d = a_gt_b;
                            hint_low_d  = !a_gt_b;
                            if (term_c) begin
                                lose_d  = 1'b1;
                                state_d = LOSE;
                            end else begin
                                state_d = WAIT_GUESS;
                            end
                        end
                    end
                end
                IDLE, WIN, LOSE: begin
                    state_d = state;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            guess_ready <= 1'b0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            hint_high   <= 1'b0;
            hint_low    <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
`ifdef GUESS_GAME_FLAG_CHECK_EN
            cmp_err     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            guess_ready <= (state_d == WAIT_GUESS);
            cmp_a       <= cmp_a_d;
            cmp_b       <= cmp_b_d;
            hint_high   <= hint_high_d;
            hint_low    <= hint_low_d;
            win         <= win_d;
            lose        <= lose_d;
`ifdef GUESS_GAME_FLAG_CHECK_EN
            cmp_err     <= cmp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Testbench for guess_game_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// game-level reference model. Set GUESS_GAME_FLAG_CHECK_EN to cover cmp_err.
module tb_guess_game_ctrl;

    localparam int unsigned MAXT = 5;

    logic       clk = 1'b0;
    logic       rst_n, secret_load, guess_valid;
    logic [3:0] secret_in, guess_in;
    logic       guess_ready;
    logic [3:0] cmp_a, cmp_b;
    logic       a_gt_b, a_lt_b, a_eq_b;
    logic       hint_high, hint_low, win, lose;
    logic [3:0] tries_used;
    logic       force_bad = 1'b0;
`ifdef GUESS_GAME_FLAG_CHECK_EN
    logic       cmp_err;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Board-level comparator; force_bad makes gt and eq both assert.
    always_comb begin
        a_gt_b = (cmp_a > cmp_b) || force_bad;
        a_lt_b = (cmp_a < cmp_b) && !force_bad;
        a_eq_b = (cmp_a == cmp_b) || force_bad;
    end

    guess_game_ctrl #(.WIDTH(4), .MAX_TRIES(MAXT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .secret_load (secret_load),
        .secret_in   (secret_in),
        .guess_valid (guess_valid),
        .guess_in    (guess_in),
        .guess_ready (guess_ready),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .a_gt_b      (a_gt_b),
        .a_lt_b      (a_lt_b),
        .a_eq_b      (a_eq_b),
        .hint_high   (hint_high),
        .hint_low    (hint_low),
        .win         (win),
        .lose        (lose),
`ifdef GUESS_GAME_FLAG_CHECK_EN
        .cmp_err     (cmp_err),
`endif
        .tries_used  (tries_used)
    );

    // Game-level reference: the secret, the pending guess, and the result of
    // judging that guess by plain arithmetic one clock after it was taken.
    logic [3:0] m_a = '0, m_b = '0;
    logic       m_ready = 1'b0, m_hi = 1'b0, m_lo = 1'b0;
    logic       m_win = 1'b0, m_lose = 1'b0, m_err = 1'b0;
    int         m_tries = 0;
    bit         m_pending = 1'b0;

    always @(posedge clk) begin
        m_err = 1'b0;
        if (!rst_n) begin
            m_a = '0; m_b = '0; m_ready = 1'b0; m_hi = 1'b0; m_lo = 1'b0;
            m_win = 1'b0; m_lose = 1'b0; m_tries = 0; m_pending = 1'b0;
        end else if (secret_load) begin
            m_b = secret_in; m_tries = 0; m_hi = 1'b0; m_lo = 1'b0;
            m_win = 1'b0; m_lose = 1'b0; m_pending = 1'b0; m_ready = 1'b1;
        end else if (m_pending) begin
            m_pending = 1'b0;
`ifdef GUESS_GAME_FLAG_CHECK_EN
            if (force_bad) begin
                m_err   = 1'b1;
                m_ready = 1'b1;
            end else
`endif
            begin
                m_tries = m_tries + 1;
                if (m_a == m_b) begin
                    m_win = 1'b1;
                end else begin
                    m_hi = (m_a > m_b);
                    m_lo = (m_a < m_b);
                    if (m_tries == int'(MAXT)) m_lose = 1'b1;
                end
                m_ready = !(m_win || m_lose);
            end
        end else if (m_ready && guess_valid) begin
            m_a = guess_in; m_hi = 1'b0; m_lo = 1'b0;
            m_pending = 1'b1; m_ready = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({guess_ready, cmp_a, cmp_b, hint_high, hint_low, win, lose, tries_used} !==
                {m_ready, m_a, m_b, m_hi, m_lo, m_win, m_lose, 4'(m_tries)}) begin
                errors++;
                $display("FAIL model_cycle t=%0t got rdy=%b a=%h b=%h hi=%b lo=%b win=%b lose=%b tries=%0d exp rdy=%b a=%h b=%h hi=%b lo=%b win=%b lose=%b tries=%0d",
                         $time, guess_ready, cmp_a, cmp_b, hint_high, hint_low, win, lose, tries_used,
                         m_ready, m_a, m_b, m_hi, m_lo, m_win, m_lose, m_tries);
            end
`ifdef GUESS_GAME_FLAG_CHECK_EN
            checks++;
            if (cmp_err !== m_err) begin
                errors++;
                $display("FAIL model_cmp_err t=%0t got %b exp %b", $time, cmp_err, m_err);
            end
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] s);
        secret_load = 1'b1;
        secret_in   = s;
        tick();
        secret_load = 1'b0;
    endtask

    // Offer a guess for one cycle, then wait the compare cycle.
    task automatic guess(input logic [3:0] g);
        guess_valid = 1'b1;
        guess_in    = g;
        tick();
        guess_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; secret_load = 1'b0; secret_in = '0;
        guess_valid = 1'b1; guess_in = 4'd3;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("reset_ready", int'(guess_ready), 0);
        check("reset_outputs", int'({cmp_a, cmp_b, hint_high, hint_low, win, lose, tries_used}), 0);
        guess_valid = 1'b0;

        // Win path.
        load(4'd9);
        check("load_ready", int'(guess_ready), 1);
        guess(4'd4);
        check("win_path_low", int'({hint_high, hint_low}), 1);
        guess(4'd12);
        check("win_path_high", int'({hint_high, hint_low}), 2);
        guess(4'd9);
        check("win_flag", int'(win), 1);
        check("win_tries", int'(tries_used), 3);
        check("win_ready", int'(guess_ready), 0);
        guess(4'd1);
        check("win_sticky", int'({win, lose, guess_ready}), 4);
        check("win_tries_held", int'(tries_used), 3);

        // Lose path.
        load(4'd7);
        for (int i = 0; i < 5; i++) guess(4'(i));
        check("lose_flag", int'(lose), 1);
        check("lose_tries", int'(tries_used), 5);
        check("lose_hint", int'({hint_high, hint_low}), 1);
        guess(4'd7);
        check("lose_sticky", int'({win, lose, tries_used}), 16 + 5);

        // Load during COMPARE wins over a simultaneous guess.
        load(4'd3);
        guess_valid = 1'b1; guess_in = 4'd5;
        tick();
        secret_load = 1'b1; secret_in = 4'd2;
        tick();
        secret_load = 1'b0; guess_valid = 1'b0;
        check("prio_tries", int'(tries_used), 0);
        check("prio_hints", int'({hint_high, hint_low}), 0);
        check("prio_ready", int'(guess_ready), 1);
        check("prio_secret", int'(cmp_b), 2);
        tick();
        check("prio_no_count", int'(tries_used), 0);

        // Held valid: accepted only every other edge.
        load(4'd10);
        guess_valid = 1'b1; guess_in = 4'd5;
        repeat (4) tick();
        guess_valid = 1'b0;
        tick();
        check("hs_tries", int'(tries_used), 2);
        check("hs_hint", int'(hint_low), 1);

`ifdef GUESS_GAME_FLAG_CHECK_EN
        load(4'd6);
        guess_valid = 1'b1; guess_in = 4'd6;
        tick();
        guess_valid = 1'b0; force_bad = 1'b1;
        tick();
        force_bad = 1'b0;
        check("err_pulse", int'(cmp_err), 1);
        check("err_tries", int'(tries_used), 0);
        check("err_ready", int'(guess_ready), 1);
        check("err_hints", int'({hint_high, hint_low, win}), 0);
        tick();
        check("err_one_cycle", int'(cmp_err), 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n       = ($urandom_range(99) != 0);
            secret_load = ($urandom_range(11) == 0);
            secret_in   = 4'($urandom_range(15));
            guess_valid = ($urandom_range(1) == 1);
            guess_in    = 4'($urandom_range(15));
`ifdef GUESS_GAME_FLAG_CHECK_EN
            force_bad   = ($urandom_range(7) == 0);
`endif
            tick();
        end
        rst_n = 1'b1; secret_load = 1'b0; guess_valid = 1'b0; force_bad = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
